multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
Multi-cycle MIPS control unit, the next generation of the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and issues per-state datapath strobes. It handshakes with variable-latency instruction and data memories and counts retired instructions. It sits between the IR (op/funct) and the shared multi-cycle datapath.

Parameters:
ALUOP_W, 5, aluop width; encodings add=0, addu=1, subu=2, and=3, or=4, slt=5, lui=6, none=all-ones
CNT_W, 32, width of retired-instruction counter
EXC_VECTOR, 32'h0000_0080, exception target PC (used only with MULTI_CYCLE_CTRL_EXC_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
op  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (beq)
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
mem_write  out  1  data access is a store (valid with dmem_req)
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
s_npc  out  2  00 branch, 01 jump, 10 jr, 11 pc+4
memtoreg  out  2  00 pc+4, 01 ALU, 10 memory
reg_dst  out  2  00 rt, 01 rd, 10 $31
reg_write  out  1  register file write
if_extend  out  1  1 sign-extend, 0 zero-extend imm
alu_src  out  1  0 rt, 1 immediate
aluop  out  ALUOP_W  ALU operation
instr_cnt  out  CNT_W  retired instructions
exc  out  1  exception pulse (macro only)
exc_pc  out  32  EXC_VECTOR (macro only)

Behaviour:
- Reset (rst_n=0, async): state=FETCH, instr_cnt=0. All strobes (imem_req, dmem_req, mem_write, ir_write, pc_write, pc_write_cond, reg_write, exc) are 0 while rst_n=0. First imem_req is in the first cycle after release.
- Outputs are combinational from state and op/funct. Unlisted strobes are 0. Mux selects default to s_npc=11, memtoreg=01, reg_dst=00, aluop=none.
- FETCH: imem_req=1 held until imem_ready. In the imem_ready cycle: ir_write=1, pc_write=1, s_npc=11, then -> DECODE. With no ready, stay in FETCH indefinitely.
- DECODE:
  - j: pc_write=1, s_npc=01, -> FETCH, retire.
  - jr (op=0, funct=001000): pc_write=1, s_npc=10, -> FETCH, retire.
  - jal: -> WB.
  - beq, R-type add/addu/subu/and/or/slt, addi/addiu/andi/ori/lui, lw/sw: -> EXEC.
  - Unknown op or funct: -> FETCH, retire as NOP.
- EXEC: aluop/alu_src/if_extend per class.
  - R-type: alu_src=0.
  - addi/addiu/lui/lw/sw: alu_src=1, if_extend=1.
  - andi/ori: alu_src=1, if_extend=0.
  - beq: aluop=subu, alu_src=0, if_extend=1, pc_write_cond=1, s_npc=00, -> FETCH, retire.
  - lw/sw -> MEM; other ALU ops -> WB.
- MEM: dmem_req=1 held until dmem_ready, and mem_write=1 for sw. On ready: lw -> WB; sw -> FETCH, retire.
- WB: reg_write=1, -> FETCH, retire.
  - R-type: reg_dst=01, memtoreg=01.
  - I-type ALU: reg_dst=00, memtoreg=01.
  - lw: reg_dst=00, memtoreg=10.
  - jal: reg_dst=10, memtoreg=00.
- Retire: instr_cnt increments by 1 on the transition into FETCH. Wraps from all-ones to 0.
- Latencies with zero-wait memory, in cycles: j/jr/NOP 2, beq 3, ALU 4, jal 3, sw 4, lw 5.
- Reset mid-instruction aborts immediately to FETCH. No partial write is issued after reset asserts.

Optional Feature:
MULTI_CYCLE_CTRL_EXC_EN:
- Defined: unknown op/funct in DECODE -> EXC state. EXC drives exc=1 and pc_write=1 for one cycle; the datapath loads exc_pc=EXC_VECTOR. Then -> FETCH. The instruction is not retired (instr_cnt unchanged).
- Undefined: exc and exc_pc ports and the EXC state are absent; illegal instructions retire as NOP.

Test Plan:
- Reset: assert rst_n=0 mid-MEM of lw -> dmem_req and reg_write drop asynchronously and instr_cnt=0. After release, imem_req=1 the next cycle.
- addu with zero-wait memory -> 4 cycles. In WB: reg_write=1, reg_dst=01, aluop=1. instr_cnt 0->1.
- lw with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, mem_write=0. WB has memtoreg=10. Total 8 cycles.
- beq with zero=1 -> EXEC has pc_write_cond=1, s_npc=00, aluop=2. Next state FETCH.
- jal -> DECODE->WB with reg_dst=10, memtoreg=00, reg_write=1. sw -> mem_write=1 with dmem_req, reg_write never 1.
- op=6'b111111, both with and without MULTI_CYCLE_CTRL_EXC_EN:
  - Without: retires as NOP, instr_cnt +1.
  - With: exc=1 for one cycle, pc_write=1, exc_pc=0x80, instr_cnt unchanged.
  - Preload instr_cnt to all-ones (force) -> wraps to 0 on the next retire.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// multi_cycle_ctrl : multi-cycle MIPS control unit (FETCH/DECODE/EXEC/MEM/WB)
//                    with memory handshakes and a retired-instruction counter.
// Optional feature macro: MULTI_CYCLE_CTRL_EXC_EN (illegal-instruction trap).
// Revision: 1.0
// ============================================================================
module multi_cycle_ctrl #(
   parameter int          ALUOP_W    = 5,
   parameter int          CNT_W      = 32,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               mem_write,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         s_npc,
   output logic [1:0]         memtoreg,
   output logic [1:0]         reg_dst,
   output logic               reg_write,
   output logic               if_extend,
   output logic               alu_src,
   output logic [ALUOP_W-1:0] aluop,
   output logic [CNT_W-1:0]   instr_cnt
`ifdef MULTI_CYCLE_CTRL_EXC_EN
   ,
   output logic               exc,
   output logic [31:0]        exc_pc
`endif
);

   localparam logic [ALUOP_W-1:0] c_ALU_ADD  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] c_ALU_ADDU = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] c_ALU_SUBU = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] c_ALU_AND  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] c_ALU_OR   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] c_ALU_SLT  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] c_ALU_LUI  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] c_ALU_NONE = '1;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [5:0] c_OP_JAL   = 6'b000011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_ADDIU = 6'b001001;
   localparam logic [5:0] c_OP_ANDI  = 6'b001100;
   localparam logic [5:0] c_OP_ORI   = 6'b001101;
   localparam logic [5:0] c_OP_LUI   = 6'b001111;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;

   localparam logic [5:0] c_FN_JR   = 6'b001000;
   localparam logic [5:0] c_FN_ADD  = 6'b100000;
   localparam logic [5:0] c_FN_ADDU = 6'b100001;
   localparam logic [5:0] c_FN_SUBU = 6'b100011;
   localparam logic [5:0] c_FN_AND  = 6'b100100;
   localparam logic [5:0] c_FN_OR   = 6'b100101;
   localparam logic [5:0] c_FN_SLT  = 6'b101010;

`ifdef MULTI_CYCLE_CTRL_EXC_EN
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_EXC    = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;
`endif

   typedef enum logic [3:0] {
      CLS_ILL  = 4'd0,
      CLS_R    = 4'd1,
      CLS_JR   = 4'd2,
      CLS_J    = 4'd3,
      CLS_JAL  = 4'd4,
      CLS_BEQ  = 4'd5,
      CLS_IALU = 4'd6,
      CLS_LW   = 4'd7,
      CLS_SW   = 4'd8
   } cls_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_retire;
   logic [CNT_W-1:0]   r_instr_cnt;
   logic               w_exc;
   cls_t               w_cls;
   logic [ALUOP_W-1:0] w_aluop;
   logic               w_alu_src;
   logic               w_if_ext;

   // Instruction class and its ALU operand setup, from the IR fields.
   always_comb begin
      w_cls     = CLS_ILL;
      w_aluop   = c_ALU_NONE;
      w_alu_src = 1'b0;
      w_if_ext  = 1'b0;
      case (op)
         c_OP_RTYPE: begin
            case (funct)
               c_FN_ADD:  begin w_cls = CLS_R; w_aluop = c_ALU_ADD;  end
               c_FN_ADDU: begin w_cls = CLS_R; w_aluop = c_ALU_ADDU; end
               c_FN_SUBU: begin w_cls = CLS_R; w_aluop = c_ALU_SUBU; end
               c_FN_AND:  begin w_cls = CLS_R; w_aluop = c_ALU_AND;  end
               c_FN_OR:   begin w_cls = CLS_R; w_aluop = c_ALU_OR;   end
               c_FN_SLT:  begin w_cls = CLS_R; w_aluop = c_ALU_SLT;  end
               c_FN_JR:   w_cls = CLS_JR;
               default:   w_cls = CLS_ILL;
            endcase
         end
         c_OP_J:   w_cls = CLS_J;
         c_OP_JAL: w_cls = CLS_JAL;
         c_OP_BEQ: begin
            w_cls = CLS_BEQ; w_aluop = c_ALU_SUBU; w_if_ext = 1'b1;
         end
         c_OP_ADDI: begin
            w_cls = CLS_IALU; w_aluop = c_ALU_ADD; w_alu_src = 1'b1; w_if_ext = 1'b1;
         end
         c_OP_ADDIU: begin
            w_cls = CLS_IALU; w_aluop = c_ALU_ADDU; w_alu_src = 1'b1; w_if_ext = 1'b1;
         end
         c_OP_ANDI: begin
            w_cls = CLS_IALU; w_aluop = c_ALU_AND; w_alu_src = 1'b1;
         end
         c_OP_ORI: begin
            w_cls = CLS_IALU; w_aluop = c_ALU_OR; w_alu_src = 1'b1;
         end
         c_OP_LUI: begin
            w_cls = CLS_IALU; w_aluop = c_ALU_LUI; w_alu_src = 1'b1; w_if_ext = 1'b1;
         end
         c_OP_LW: begin
            w_cls = CLS_LW; w_aluop = c_ALU_ADDU; w_alu_src = 1'b1; w_if_ext = 1'b1;
         end
         c_OP_SW: begin
            w_cls = CLS_SW; w_aluop = c_ALU_ADDU; w_alu_src = 1'b1; w_if_ext = 1'b1;
         end
         default: w_cls = CLS_ILL;
      endcase
   end

   // Strobes and next state; strobes are forced low while reset is held.
   always_comb begin
      w_next        = r_state;
      w_retire      = 1'b0;
      w_exc         = 1'b0;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      if_extend     = 1'b0;
      alu_src       = 1'b0;
      s_npc         = 2'b11;
      memtoreg      = 2'b01;
      reg_dst       = 2'b00;
      aluop         = c_ALU_NONE;
      case (r_state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            case (w_cls)
               CLS_J: begin
                  pc_write = 1'b1; s_npc = 2'b01; w_next = S_FETCH; w_retire = 1'b1;
               end
               CLS_JR: begin
                  pc_write = 1'b1; s_npc = 2'b10; w_next = S_FETCH; w_retire = 1'b1;
               end
               CLS_JAL: w_next = S_WB;
               CLS_ILL: begin
`ifdef MULTI_CYCLE_CTRL_EXC_EN
                  w_next = S_EXC;
`else
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
`endif
               end
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            aluop     = w_aluop;
            alu_src   = w_alu_src;
            if_extend = w_if_ext;
            case (w_cls)
               CLS_BEQ: begin
                  pc_write_cond = 1'b1; s_npc = 2'b00; w_next = S_FETCH; w_retire = 1'b1;
               end
               CLS_LW, CLS_SW: w_next = S_MEM;
               default:        w_next = S_WB;
            endcase
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            mem_write = (w_cls == CLS_SW);
            if (dmem_ready) begin
               if (w_cls == CLS_SW) begin
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            aluop     = w_aluop;
            alu_src   = w_alu_src;
            if_extend = w_if_ext;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
            case (w_cls)
               CLS_R:   reg_dst = 2'b01;
               CLS_LW:  memtoreg = 2'b10;
               CLS_JAL: begin reg_dst = 2'b10; memtoreg = 2'b00; end
               default: reg_dst = 2'b00;
            endcase
         end
`ifdef MULTI_CYCLE_CTRL_EXC_EN
         S_EXC: begin
            w_exc    = 1'b1;
            pc_write = 1'b1;
            w_next   = S_FETCH;
         end
`endif
         default: w_next = S_FETCH;
      endcase
      if (!rst_n) begin
         imem_req      = 1'b0;
         dmem_req      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         reg_write     = 1'b0;
         w_exc         = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_instr_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         end
      end
   end

   assign instr_cnt = r_instr_cnt;

   // The branch decision is taken by the datapath from pc_write_cond and zero.
`ifdef MULTI_CYCLE_CTRL_EXC_EN
   assign exc    = w_exc;
   assign exc_pc = EXC_VECTOR;
   logic w_unused;
   assign w_unused = zero;
`else
   logic w_unused;
   assign w_unused = ^{zero, w_exc, EXC_VECTOR};
`endif

endmodule
`default_nettype wire
